flags_int_unit: RTL
===================

Name: flags_int_unit

Overview:
- Status and interrupt front-end feeding the microsequencer.
- Holds the architectural flags Z/N/C/P, latched from the ALU under microcode control, and drives them to the sequencer's jump-condition inputs.
- Collects edge-triggered IRQ lines, applies mask and global enable, and raises a single `int` request.
- On microcode acknowledge: supplies a vector, shadows the flags, and restores them on return-from-interrupt.

Parameters:
- NUM_IRQ, 4, number of interrupt sources (2..8); index 0 is highest priority.
- VEC_W, 3, width of irq_vec; must satisfy 2**VEC_W >= NUM_IRQ.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- alu_z, alu_n, alu_c, alu_p  in  1 each  ALU status of current op
- flag_we  in  1  microinstruction field: latch alu_* into flags
- irq  in  NUM_IRQ  level interrupt lines; rising edge = request
- mask_we  in  1  write mask register
- mask_d  in  NUM_IRQ  new mask (1 = enabled)
- ei  in  1  set global interrupt enable
- di  in  1  clear global interrupt enable
- int_ack  in  1  microcode accepted interrupt
- reti  in  1  microcode return-from-interrupt
- Z, N, C, P  out  1 each  registered flags
- int  out  1  interrupt request to sequencer
- irq_vec  out  VEC_W  vector captured at ack
- in_service  out  1  high while handler runs

Behaviour:
- Reset (rst=1 at edge): flags=0, pending=0, mask=all-1, ie=0, irq_vec=0, irq_prev=0, shadow=0, state=IDLE. Reset mid-service aborts the service with no restore.
- Flags: on flag_we, {Z,N,C,P} <= {alu_z,alu_n,alu_c,alu_p} at next edge. One-cycle latency.
- Edge detect: pending[i] set when irq[i]=1 and irq_prev[i]=0. irq_prev <= irq every cycle.
- Mask: mask_we loads mask_d. Pending bits are kept when masked.
- ie: ei sets it and di clears it. ei and di in the same cycle → di wins.
- Combinational request: req = ie & |(pending & mask) & (state==IDLE). int = req, with no added register.
- FSM:
  - IDLE → SERVICE on int_ack & req. At that edge:
    - irq_vec <= lowest index of pending&mask.
    - That pending bit is cleared.
    - shadow <= {Z,N,C,P}.
    - ie <= 0.
  - int_ack while req=0 is ignored: no state change, irq_vec holds.
  - SERVICE → IDLE on reti. At that edge flags <= shadow and ie <= 1. reti in IDLE is ignored.
  - in_service = (state==SERVICE).
- Simultaneous events:
  - Same-cycle new edge on the bit being acked → pending stays 1.
  - flag_we with reti → reti restore wins.
  - flag_we with int_ack → flags take ALU values, shadow takes pre-edge flags.
  - ei with int_ack → ie ends 0.
  - ei/di during SERVICE are applied, but int stays 0 until IDLE.

Optional Feature:
- IRQ_SYNC_EN defined: two-flop synchronizer on each irq bit ahead of edge detect. Edge-to-int latency = 3 cycles; synchronizer flops reset to 0.
- Undefined: irq feeds edge detect directly. Edge-to-int latency = 1 cycle (pending visible the cycle after the edge).

Decomposition:
- Shared package:
  - FSM state enum (ST_IDLE=1'b0, ST_SERVICE=1'b1).
  - Flag bit-index constants (FLG_Z=3, FLG_N=2, FLG_C=1, FLG_P=0).
  - Default NUM_IRQ/VEC_W.
- One sub-module: prio_enc (NUM_IRQ-in, VEC_W-out, plus valid), purely combinational; instantiated once.

Test Plan:
- Reset: rst=1 one cycle, then irq=4'b1111 with ie=0 → Z=N=C=P=0, int=0, pending=4'b1111, in_service=0.
- Flag latch/restore:
  - Sequence: flag_we with alu=1010 → {Z,N,C,P}=1010 next cycle; ei; irq[2] edge → int=1; int_ack.
  - After ack: flag_we alu=0101 → flags 0101.
  - reti → flags 1010, ie=1, in_service=0.
- Priority/mask:
  - pending=4'b1010, mask=4'b1111, ie=1, int_ack → irq_vec=1, pending=4'b1000.
  - After reti → int=1 again; next ack → irq_vec=3.
  - With mask=4'b0111 and pending=4'b1000 → int=0.
- Simultaneous:
  - ei&di same cycle → ie=0.
  - irq[0] re-edge in the ack cycle of vector 0 → pending[0] remains 1.
  - flag_we+reti same cycle → shadow values win.
- Spurious: int_ack with ie=0 and pending=4'b0001 → state IDLE, irq_vec unchanged; reti in IDLE → no flag change.
- Reset mid-service: in SERVICE with shadow=1111, assert rst → flags 0000, in_service=0, ie=0. A later reti has no effect.
- With IRQ_SYNC_EN: edge on irq[1] at cycle t → int=1 at t+3, not earlier.

Source files
------------

// File: rtl/flags_int_unit_pkg.sv
// Shared types and constants for the flags/interrupt front-end: FSM state,
// flag bit positions inside the packed {Z,N,C,P} vector, default sizing.
package flags_int_unit_pkg;

  localparam int NUM_IRQ_DEF = 4;
  localparam int VEC_W_DEF   = 3;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_SERVICE = 1'b1
  } state_e;

  localparam int FLG_Z = 3;
  localparam int FLG_N = 2;
  localparam int FLG_C = 1;
  localparam int FLG_P = 0;

endpackage

// File: rtl/flags_int_unit_if.sv
// Bundle between the microsequencer (master) and the flags/interrupt unit
// (slave); i_* are driven toward the unit, o_* come back from it.
interface flags_int_unit_if
  import flags_int_unit_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int VEC_W   = VEC_W_DEF
);
  logic               i_alu_z;
  logic               i_alu_n;
  logic               i_alu_c;
  logic               i_alu_p;
  logic               i_flag_we;
  logic [NUM_IRQ-1:0] i_irq;
  logic               i_mask_we;
  logic [NUM_IRQ-1:0] i_mask_d;
  logic               i_ei;
  logic               i_di;
  logic               i_int_ack;
  logic               i_reti;
  logic               o_z;
  logic               o_n;
  logic               o_c;
  logic               o_p;
  logic               o_int;
  logic [VEC_W-1:0]   o_irq_vec;
  logic               o_in_service;

  modport master (
    output i_alu_z, i_alu_n, i_alu_c, i_alu_p, i_flag_we, i_irq,
           i_mask_we, i_mask_d, i_ei, i_di, i_int_ack, i_reti,
    input  o_z, o_n, o_c, o_p, o_int, o_irq_vec, o_in_service
  );

  modport slave (
    input  i_alu_z, i_alu_n, i_alu_c, i_alu_p, i_flag_we, i_irq,
           i_mask_we, i_mask_d, i_ei, i_di, i_int_ack, i_reti,
    output o_z, o_n, o_c, o_p, o_int, o_irq_vec, o_in_service
  );
endinterface

// File: rtl/flags_int_unit_prio_enc.sv
// Combinational priority encoder: reports the lowest set index and whether
// any bit is set at all.
module flags_int_unit_prio_enc #(
  parameter int NUM_IRQ = 4,
  parameter int VEC_W   = 3
) (
  input  logic [NUM_IRQ-1:0] i_req,
  output logic [VEC_W-1:0]   o_idx,
  output logic               o_valid
);

  // NOTE: every output gets a default before the loop so no latch is inferred.
  always_comb begin
    o_idx   = '0;
    o_valid = 1'b0;
    // Scan downward so the lowest index is the last one written and wins.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_idx   = VEC_W'(i);
        o_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/flags_int_unit.sv
// Flags Z/N/C/P plus edge-triggered interrupt controller for the microsequencer.
// Define IRQ_SYNC_EN to put a two-flop synchronizer ahead of the irq edge detector.
module flags_int_unit
  import flags_int_unit_pkg::*;
#(
  parameter int NUM_IRQ = NUM_IRQ_DEF,
  parameter int VEC_W   = VEC_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  flags_int_unit_if.slave       bus
);

  logic [3:0]         r_flags;
  logic [3:0]         r_shadow;
  logic [NUM_IRQ-1:0] r_pending;
  logic [NUM_IRQ-1:0] r_mask;
  logic [NUM_IRQ-1:0] r_irq_prev;
  logic [VEC_W-1:0]   r_irq_vec;
  logic               r_ie;
  state_e             r_state;
  state_e             w_state_nxt;

  logic [NUM_IRQ-1:0] w_irq_s;
  logic [NUM_IRQ-1:0] w_active;
  logic [NUM_IRQ-1:0] w_rise;
  logic [NUM_IRQ-1:0] w_clr;
  logic [VEC_W-1:0]   w_vec;
  logic               w_any;
  logic               w_req;
  logic               w_ack_fire;
  logic               w_reti_fire;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] r_sync1;
  logic [NUM_IRQ-1:0] r_sync2;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= bus.i_irq;
      r_sync2 <= r_sync1;
    end
  end

  assign w_irq_s = r_sync2;
`else
  assign w_irq_s = bus.i_irq;
`endif

  flags_int_unit_prio_enc #(
    .NUM_IRQ (NUM_IRQ),
    .VEC_W   (VEC_W)
  ) u_prio_enc (
    .i_req   (w_active),
    .o_idx   (w_vec),
    .o_valid (w_any)
  );

  assign w_active    = r_pending & r_mask;
  assign w_rise      = w_irq_s & ~r_irq_prev;
  assign w_req       = r_ie & w_any & (r_state == ST_IDLE);
  assign w_ack_fire  = bus.i_int_ack & w_req;
  assign w_reti_fire = bus.i_reti & (r_state == ST_SERVICE);
  assign w_clr       = w_ack_fire ? (NUM_IRQ'(1) << w_vec) : '0;

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE:    if (w_ack_fire)  w_state_nxt = ST_SERVICE;
      ST_SERVICE: if (w_reti_fire) w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, e.g. shadow captures flags before flag_we lands.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_flags    <= '0;
      r_shadow   <= '0;
      r_pending  <= '0;
      r_mask     <= '1;
      r_irq_prev <= '0;
      r_irq_vec  <= '0;
      r_ie       <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_irq_prev <= w_irq_s;
      // A fresh edge on the bit being acknowledged re-arms it.
      r_pending  <= (r_pending & ~w_clr) | w_rise;

      if (bus.i_mask_we) r_mask <= bus.i_mask_d;

      if (w_reti_fire)         r_flags <= r_shadow;
      else if (bus.i_flag_we)  r_flags <= {bus.i_alu_z, bus.i_alu_n, bus.i_alu_c, bus.i_alu_p};

      if (w_ack_fire) begin
        r_shadow  <= r_flags;
        r_irq_vec <= w_vec;
      end

      if (w_ack_fire)       r_ie <= 1'b0;
      else if (w_reti_fire) r_ie <= 1'b1;
      else if (bus.i_di)    r_ie <= 1'b0;
      else if (bus.i_ei)    r_ie <= 1'b1;
    end
  end

  assign bus.o_z          = r_flags[FLG_Z];
  assign bus.o_n          = r_flags[FLG_N];
  assign bus.o_c          = r_flags[FLG_C];
  assign bus.o_p          = r_flags[FLG_P];
  assign bus.o_int        = w_req;
  assign bus.o_irq_vec    = r_irq_vec;
  assign bus.o_in_service = (r_state == ST_SERVICE);

endmodule
